ibex_multdiv_ctrl: RTL

- EX-stage sequencer placed directly upstream of the slow iterative multiplier/divider.
- Accepts one MUL/DIV request from ID through a valid/ready handshake and latches its operands and destination tag.
- Holds mult_en/div_en steady until the multiplier/divider reports valid, captures the result, then presents it to writeback through a valid/ready handshake.
- Also provides the shared 34-bit adder that the multiplier/divider uses as its ALU.

---
 rtl/ibex_multdiv_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ibex_multdiv_ctrl.sv
// ibex_multdiv_ctrl: EX-stage sequencer and shared 34-bit adder for multdiv.
// Optional perf counters enabled by defining MULTDIV_CTRL_PERF_CNT_EN.
module ibex_multdiv_ctrl #(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_operator_i,
  input  logic [1:0]       req_signed_mode_i,
  input  logic [31:0]      req_op_a_i,
  input  logic [31:0]      req_op_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             flush_i,
  output logic             mult_en_o,
  output logic             div_en_o,
  output logic [1:0]       operator_o,
  output logic [1:0]       signed_mode_o,
  output logic [31:0]      op_a_o,
  output logic [31:0]      op_b_o,
  output logic             equal_to_zero_o,
  input  logic [32:0]      alu_operand_a_i,
  input  logic [32:0]      alu_operand_b_i,
  output logic [33:0]      alu_adder_ext_o,
  output logic [31:0]      alu_adder_o,
  input  logic [31:0]      multdiv_result_i,
  input  logic             multdiv_valid_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [31:0]      wb_result_o,
  output logic [TAG_W-1:0] wb_tag_o
`ifdef MULTDIV_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]      perf_busy_cycles_o,
  output logic [15:0]      perf_ops_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q;
  logic [1:0]        operator_q;
  logic [1:0]        signed_mode_q;
  logic [31:0]       op_a_q;
  logic [31:0]       op_b_q;
  logic [TAG_W-1:0]  tag_q;
  logic [31:0]       wb_result_q;
  logic [TAG_W-1:0]  wb_tag_q;
  logic              active;
  logic              accept;

  // Shared adder, full carry kept in the extended sum.
  assign alu_adder_ext_o = {1'b0, alu_operand_a_i} + {1'b0, alu_operand_b_i};
  assign alu_adder_o     = alu_adder_ext_o[32:1];

  // Enables follow the state so the unit finishes even when flushed.
  assign active    = (state_q == BUSY) | (state_q == FLUSH);
  assign mult_en_o = active & ~operator_q[1];
  assign div_en_o  = active &  operator_q[1];

  assign req_ready_o = ~flush_i &
                       ((state_q == IDLE) |
                        ((state_q == DONE) & wb_ready_i));
  assign accept      = req_valid_i & req_ready_o;

  assign operator_o      = operator_q;
  assign signed_mode_o   = signed_mode_q;
  assign op_a_o          = op_a_q;
  assign op_b_o          = op_b_q;
  assign equal_to_zero_o = (op_b_q == 32'd0);
  assign wb_valid_o      = (state_q == DONE);
  assign wb_result_o     = wb_result_q;
  assign wb_tag_o        = wb_tag_q;

  // Request latch, sequencing FSM and writeback result register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      operator_q    <= 2'd0;
      signed_mode_q <= 2'd0;
      op_a_q        <= 32'd0;
      op_b_q        <= 32'd0;
      tag_q         <= '0;
      wb_result_q   <= 32'd0;
      wb_tag_q      <= '0;
    end else begin
      if (accept) begin
        operator_q    <= req_operator_i;
        signed_mode_q <= req_signed_mode_i;
        op_a_q        <= req_op_a_i;
        op_b_q        <= req_op_b_i;
        tag_q         <= req_tag_i;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) state_q <= BUSY;
        end
        BUSY: begin
          if (multdiv_valid_i && !flush_i) begin
            wb_result_q <= multdiv_result_i;
            wb_tag_q    <= tag_q;
            state_q     <= DONE;
          end else if (multdiv_valid_i) begin
            state_q <= IDLE;
          end else if (flush_i) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (multdiv_valid_i) state_q <= IDLE;
        end
        DONE: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else if (wb_ready_i) begin
            state_q <= accept ? BUSY : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MULTDIV_CTRL_PERF_CNT_EN
  logic [31:0] busy_cnt_q;
  logic [15:0] ops_cnt_q;

  // Busy-cycle and retired-op counters, both free-running and wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_cnt_q <= 32'd0;
      ops_cnt_q  <= 16'd0;
    end else begin
      if (active) busy_cnt_q <= busy_cnt_q + 32'd1;
      if ((state_q == DONE) && wb_ready_i && !flush_i)
        ops_cnt_q <= ops_cnt_q + 16'd1;
    end
  end

  assign perf_busy_cycles_o = busy_cnt_q;
  assign perf_ops_o         = ops_cnt_q;
`endif

endmodule
